// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues imem requests, and fills the IF/ID register.
// Latency: fetched word appears in IF/ID on the edge that completes the request; sustains 1/cycle.
// Backpressure: stall holds PC and IF/ID; a word returned during stall parks in a one-entry skid buffer.
//
// Ports: clk/rst (sync, active-high); stall from the hazard unit; PCSrc plus the ID-stage imm16,
// instr_index and rs value select the redirect target; imem_req/imem_addr/imem_rdata/imem_ready
// form the fetch handshake; ifid_instr/ifid_pc4/ifid_valid feed decode.
module if_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      PCSrc,
    input  logic [15:0]     id_imm16,
    input  logic [25:0]     id_instr_index,
    input  logic [31:0]     id_rs_value,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc4,
    output logic            ifid_valid
);

    typedef enum logic [1:0] {IDLE, REQ, HELD} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic            squash_q, squash_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [PC_W-1:0] hold_pc4_q, hold_pc4_d;

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] target;
    logic            redirect;
    logic            unused_rs_low;

    assign unused_rs_low = ^id_rs_value[1:0];

    assign pc_plus4 = pc_q + PC_W'(4);

    // The ID instruction only resolves once it is real and not held by the hazard unit.
    assign redirect = ifid_valid_q & ~stall & (PCSrc != 2'b00);

    always_comb begin
        target = pc_plus4;
        case (PCSrc)
            2'b01:   target = ifid_pc4_q + {{(PC_W-18){id_imm16[15]}}, id_imm16, 2'b00};
            2'b10:   target = {ifid_pc4_q[PC_W-1:28], id_instr_index, 2'b00};
            2'b11:   target = {id_rs_value[PC_W-1:2], 2'b00};
            default: target = pc_plus4;
        endcase
    end

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            squash_q     <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            squash_q     <= squash_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        squash_d     = squash_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = pc_q;
            end
            REQ: begin
                if (imem_ready) begin
                    if (redirect || squash_q) begin
                        // Returned word is on the wrong path; re-issue at the target.
                        ifid_valid_d = 1'b0;
                        squash_d     = 1'b0;
                        if (redirect) begin
                            pc_d       = target;
                            req_addr_d = target;
                        end else begin
                            req_addr_d = pc_q;
                        end
                    end else if (stall) begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = HELD;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        req_addr_d   = pc_plus4;
                    end
                end else begin
                    // Address must stay put until the request completes, so a redirect
                    // only retargets pc and marks the in-flight word for discard.
                    if (redirect) begin
                        pc_d         = target;
                        squash_d     = 1'b1;
                        ifid_valid_d = 1'b0;
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
            end
            HELD: begin
                if (!stall) begin
                    state_d = REQ;
                    if (redirect) begin
                        ifid_valid_d = 1'b0;
                        pc_d         = target;
                        req_addr_d   = target;
                    end else begin
                        ifid_instr_d = hold_instr_q;
                        ifid_pc4_d   = hold_pc4_q;
                        ifid_valid_d = 1'b1;
                        pc_d         = hold_pc4_q;
                        req_addr_d   = hold_pc4_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        imem_req   = (state_q == REQ);
        imem_addr  = {req_addr_q[PC_W-1:2], 2'b00};
        ifid_instr = ifid_instr_q;
        ifid_pc4   = ifid_pc4_q;
        ifid_valid = ifid_valid_q;
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [15:0] id_imm16 = '0;
    logic [25:0] id_instr_index = '0;
    logic [31:0] id_rs_value = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    if_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .PCSrc          (PCSrc),
        .id_imm16       (id_imm16),
        .id_instr_index (id_instr_index),
        .id_rs_value    (id_rs_value),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a);
        exp_t e;
        e.instr = mem_word(a);
        e.pc4   = a + 32'd4;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then sample just after the edge. IF/ID takes a new
    // value only on an edge where stall was low, so that is when the scoreboard pops.
    task automatic step(input logic rdy, input logic stl, input logic [1:0] src);
        exp_t e;
        imem_ready = rdy;
        stall      = stl;
        PCSrc      = src;
        imem_rdata = mem_word(imem_addr);
        @(posedge clk);
        #1;
        if (!stl && ifid_valid) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("sb_pc4", ifid_pc4, e.pc4);
                check_eq("sb_instr", ifid_instr, e.instr);
            end
        end
    endtask

    initial begin
        logic [31:0] a;

        // 1. Reset then sequential fetch with zero-wait memory.
        rst = 1'b1;
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(ifid_valid), 32'd0);
        check_eq("rst_instr", ifid_instr, 32'd0);
        check_eq("rst_pc4", ifid_pc4, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        rst = 1'b0;
        step(1'b1, 1'b0, 2'b00);
        check_eq("seq_first_req", 32'(imem_req), 32'd1);
        check_eq("seq_first_addr", imem_addr, 32'h0);
        check_eq("seq_valid_late", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            a = 32'(i) * 32'd4;
            check_eq("seq_addr", imem_addr, a);
            exp_push(a);
            step(1'b1, 1'b0, 2'b00);
            check_eq("seq_valid", 32'(ifid_valid), 32'd1);
        end
        check_eq("seq_addr_end", imem_addr, 32'h10);

        // 3. Stall while the fetch at 0x10 completes.
        exp_push(32'h10);
        step(1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            check_eq("stall_req", 32'(imem_req), 32'd0);
            check_eq("stall_pc4", ifid_pc4, 32'h10);
            check_eq("stall_valid", 32'(ifid_valid), 32'd1);
            step(1'b0, 1'b1, 2'b00);
        end
        check_eq("stall_req3", 32'(imem_req), 32'd0);
        check_eq("stall_pc4_3", ifid_pc4, 32'h10);
        step(1'b0, 1'b0, 2'b00);
        check_eq("unstall_pc4", ifid_pc4, 32'h14);
        check_eq("unstall_addr", imem_addr, 32'h14);
        check_eq("unstall_req", 32'(imem_req), 32'd1);

        // 2. Two wait states per access.
        a = 32'h14;
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 2; w++) begin
                step(1'b0, 1'b0, 2'b00);
                check_eq("wait_addr", imem_addr, a);
                check_eq("wait_valid", 32'(ifid_valid), 32'd0);
            end
            exp_push(a);
            step(1'b1, 1'b0, 2'b00);
            check_eq("wait_done_valid", 32'(ifid_valid), 32'd1);
            a = a + 32'd4;
            check_eq("wait_next_addr", imem_addr, a);
        end

        // 4. Taken beq from ifid_pc4=0x20 with offset -2 words.
        check_eq("beq_pre_pc4", ifid_pc4, 32'h20);
        id_imm16 = 16'hFFFE;
        step(1'b1, 1'b0, 2'b01);
        check_eq("beq_valid", 32'(ifid_valid), 32'd0);
        check_eq("beq_addr", imem_addr, 32'h18);
        exp_push(32'h18);
        step(1'b1, 1'b0, 2'b00);
        check_eq("beq_after_addr", imem_addr, 32'h1C);

        // 5. jr while the fetch at 0x1C is still waiting.
        id_rs_value = 32'h103;
        step(1'b0, 1'b0, 2'b11);
        check_eq("jr_valid", 32'(ifid_valid), 32'd0);
        check_eq("jr_addr_held", imem_addr, 32'h1C);
        step(1'b0, 1'b0, 2'b00);
        check_eq("jr_addr_held2", imem_addr, 32'h1C);
        step(1'b1, 1'b0, 2'b00);
        check_eq("jr_squash_valid", 32'(ifid_valid), 32'd0);
        check_eq("jr_target_addr", imem_addr, 32'h100);
        exp_push(32'h100);
        step(1'b1, 1'b0, 2'b00);
        check_eq("jr_after_addr", imem_addr, 32'h104);

        // j resolving on the cycle stall drops, while a word sits in the skid buffer.
        step(1'b1, 1'b1, 2'b00);
        check_eq("held_req", 32'(imem_req), 32'd0);
        id_instr_index = 26'h80;
        step(1'b0, 1'b0, 2'b10);
        check_eq("j_held_valid", 32'(ifid_valid), 32'd0);
        check_eq("j_held_addr", imem_addr, 32'h200);
        check_eq("j_held_req", 32'(imem_req), 32'd1);
        exp_push(32'h200);
        step(1'b1, 1'b0, 2'b00);
        check_eq("j_after_addr", imem_addr, 32'h204);

        // 6. Reset while a request is waiting.
        step(1'b0, 1'b0, 2'b00);
        rst = 1'b1;
        step(1'b0, 1'b0, 2'b00);
        check_eq("mrst_req", 32'(imem_req), 32'd0);
        check_eq("mrst_valid", 32'(ifid_valid), 32'd0);
        check_eq("mrst_instr", ifid_instr, 32'd0);
        check_eq("mrst_pc4", ifid_pc4, 32'd0);
        check_eq("mrst_addr", imem_addr, 32'd0);
        rst = 1'b0;
        step(1'b1, 1'b0, 2'b00);
        check_eq("mrst_idle_valid", 32'(ifid_valid), 32'd0);
        check_eq("mrst_req_addr", imem_addr, 32'h0);
        check_eq("mrst_req_on", 32'(imem_req), 32'd1);
        exp_push(32'h0);
        step(1'b1, 1'b0, 2'b00);
        check_eq("mrst_first_pc4", ifid_pc4, 32'h4);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
